// File: rtl/range_tracker_pkg.sv
// Shared types for the multi-channel range tracker.
// Result records are carried at a fixed maximum width; the channel fills
// the low WIDTH / CNT_W bits, so WIDTH must not exceed RT_MAX_W and CNT_W
// must not exceed RT_MAX_CNT_W.
package range_tracker_pkg;

  localparam int RT_MAX_W     = 64;
  localparam int RT_MAX_CNT_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  // Encoding is {go, finish} so a beat decodes with a plain cast.
  typedef enum logic [1:0] {
    BEAT_SAMPLE = 2'b00,
    BEAT_FINISH = 2'b01,
    BEAT_GO     = 2'b10,
    BEAT_SINGLE = 2'b11
  } beat_kind_e;

  typedef struct packed {
    logic [RT_MAX_W-1:0]     minVal;
    logic [RT_MAX_W-1:0]     maxVal;
    logic [RT_MAX_CNT_W-1:0] count;
  } rt_result_t;

  function automatic beat_kind_e decodeBeat(input logic go, input logic finish);
    return beat_kind_e'({go, finish});
  endfunction

endpackage

// File: rtl/range_channel.sv
// One channel of the range tracker: IDLE/RUN state, running min/max,
// saturating sample count and a sticky protocol-error bit.
// resValid_o/res_o are combinational and describe the measurement that
// closes on this cycle's beat; the top level registers them.
// Macro RANGE_TRACKER_SIGNED_EN switches min/max compares to two's complement.
module range_channel
  import range_tracker_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hit_i,
  input  beat_kind_e       kind_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             errClr_i,
  output logic             resValid_o,
  output rt_result_t       res_o,
  output logic             error_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             newErr;

  logic [WIDTH-1:0] updMin;
  logic [WIDTH-1:0] updMax;
  logic [CNT_W-1:0] updCnt;

  function automatic logic lessThan(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef RANGE_TRACKER_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  // Running statistics if this beat's sample joins the open measurement.
  always_comb begin
    updMin = lessThan(data_i, min_q) ? data_i : min_q;
    updMax = lessThan(max_q, data_i) ? data_i : max_q;
    updCnt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Beat handling: next state, statistics, error detection and result.
  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    max_d      = max_q;
    cnt_d      = cnt_q;
    newErr     = 1'b0;
    resValid_o = 1'b0;
    if (hit_i) begin
      case (kind_i)
        BEAT_GO: begin
          newErr  = (state_q == RUN);
          state_d = RUN;
          min_d   = data_i;
          max_d   = data_i;
          cnt_d   = CNT_W'(1);
        end
        BEAT_SAMPLE: begin
          if (state_q == RUN) begin
            min_d = updMin;
            max_d = updMax;
            cnt_d = updCnt;
          end else begin
            newErr = 1'b1;
          end
        end
        BEAT_FINISH: begin
          if (state_q == RUN) begin
            min_d      = updMin;
            max_d      = updMax;
            cnt_d      = updCnt;
            state_d    = IDLE;
            resValid_o = 1'b1;
          end else begin
            newErr = 1'b1;
          end
        end
        BEAT_SINGLE: begin
          newErr     = (state_q == RUN);
          state_d    = IDLE;
          min_d      = data_i;
          max_d      = data_i;
          cnt_d      = CNT_W'(1);
          resValid_o = 1'b1;
        end
        default: begin
          newErr = 1'b0;
        end
      endcase
    end
    err_d = (errClr_i ? 1'b0 : err_q) | newErr;
    res_o = '0;
    res_o.minVal[WIDTH-1:0] = min_d;
    res_o.maxVal[WIDTH-1:0] = max_d;
    res_o.count[CNT_W-1:0]  = cnt_d;
  end

  // Channel registers; reset returns the channel to IDLE with cleared stats.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      min_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign error_o = err_q;

endmodule

// File: rtl/range_tracker.sv
// Multi-channel range tracker: decodes the tagged beat stream, steers each
// beat to its channel and registers the closing channel's result.
// Beats tagged with a channel number >= NCH are silently dropped.
// Macro RANGE_TRACKER_SIGNED_EN: signed min/max compares (default unsigned).
module range_tracker
  import range_tracker_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 2,
  parameter int CNT_W = 8,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [CH_W-1:0]  in_ch,
  input  logic             in_go,
  input  logic             in_finish,
  input  logic [WIDTH-1:0] in_data,
  input  logic             err_clr,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_range,
  output logic [CNT_W-1:0] out_count,
  output logic [NCH-1:0]   error
);

  beat_kind_e       beatKind;
  logic [NCH-1:0]   chHit;
  logic [NCH-1:0]   chResValid;
  logic [NCH-1:0]   chErr;
  rt_result_t       chRes [NCH];

  logic             anyRes;
  logic [CH_W-1:0]  selCh;
  rt_result_t       selRes;
  logic             unusedResParity;

  logic             valid_q, valid_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] range_q, range_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign beatKind = decodeBeat(in_go, in_finish);

  for (genvar g = 0; g < NCH; g++) begin : gCh
    assign chHit[g] = in_valid && (in_ch == CH_W'(g));

    range_channel #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) uChannel (
      .clock      (clock),
      .reset      (reset),
      .hit_i      (chHit[g]),
      .kind_i     (beatKind),
      .data_i     (in_data),
      .errClr_i   (err_clr),
      .resValid_o (chResValid[g]),
      .res_o      (chRes[g]),
      .error_o    (chErr[g])
    );
  end

  // Pick the channel closing this cycle; only the addressed channel can close.
  always_comb begin
    anyRes = 1'b0;
    selCh  = '0;
    selRes = '0;
    for (int i = 0; i < NCH; i++) begin
      if (chResValid[i]) begin
        anyRes = 1'b1;
        selCh  = CH_W'(i);
        selRes = chRes[i];
      end
    end
  end

  assign unusedResParity = ^selRes;

  // Next output values; data fields hold until a new result arrives.
  always_comb begin
    valid_d = anyRes;
    ch_d    = ch_q;
    min_d   = min_q;
    max_d   = max_q;
    range_d = range_q;
    cnt_d   = cnt_q;
    if (anyRes) begin
      ch_d    = selCh;
      min_d   = selRes.minVal[WIDTH-1:0];
      max_d   = selRes.maxVal[WIDTH-1:0];
      range_d = selRes.maxVal[WIDTH-1:0] - selRes.minVal[WIDTH-1:0];
      cnt_d   = selRes.count[CNT_W-1:0];
    end
  end

  // Output register bank.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      min_q   <= '0;
      max_q   <= '0;
      range_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ch_q    <= ch_d;
      min_q   <= min_d;
      max_q   <= max_d;
      range_q <= range_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_ch    = ch_q;
  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_range = range_q;
  assign out_count = cnt_q;
  assign error     = chErr;

endmodule

// File: tb/tb_range_tracker.sv
// Testbench for range_tracker (WIDTH=16, NCH=2, CNT_W=8).
// Expected values adapt to RANGE_TRACKER_SIGNED_EN for the signed test.
module tb_range_tracker;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ch;
  logic        in_go;
  logic        in_finish;
  logic [15:0] in_data;
  logic        err_clr;
  logic        out_valid;
  logic        out_ch;
  logic [15:0] out_min;
  logic [15:0] out_max;
  logic [15:0] out_range;
  logic [7:0]  out_count;
  logic [1:0]  error;

  int checks;
  int failures;

`ifdef RANGE_TRACKER_SIGNED_EN
  localparam logic [15:0] SGN_MIN   = 16'hFFFE;
  localparam logic [15:0] SGN_MAX   = 16'h0003;
  localparam logic [15:0] SGN_RANGE = 16'h0005;
`else
  localparam logic [15:0] SGN_MIN   = 16'h0003;
  localparam logic [15:0] SGN_MAX   = 16'hFFFE;
  localparam logic [15:0] SGN_RANGE = 16'hFFFB;
`endif

  typedef struct {
    logic        v;
    logic        ch;
    logic        go;
    logic        fin;
    logic [15:0] data;
    logic        clr;
    logic        eValid;
    logic        eCh;
    logic [15:0] eMin;
    logic [15:0] eMax;
    logic [15:0] eRange;
    logic [7:0]  eCnt;
    logic [1:0]  eErr;
  } vec_t;

  vec_t vecs[$];

  range_tracker #(
    .WIDTH (16),
    .NCH   (2),
    .CNT_W (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .in_go     (in_go),
    .in_finish (in_finish),
    .in_data   (in_data),
    .err_clr   (err_clr),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_range (out_range),
    .out_count (out_count),
    .error     (error)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  function automatic void addVec(input logic v, input logic ch, input logic go,
                                 input logic fin, input logic [15:0] data,
                                 input logic clr, input logic eValid,
                                 input logic eCh, input logic [15:0] eMin,
                                 input logic [15:0] eMax, input logic [15:0] eRange,
                                 input logic [7:0] eCnt, input logic [1:0] eErr);
    vec_t t;
    t.v = v; t.ch = ch; t.go = go; t.fin = fin; t.data = data; t.clr = clr;
    t.eValid = eValid; t.eCh = eCh; t.eMin = eMin; t.eMax = eMax;
    t.eRange = eRange; t.eCnt = eCnt; t.eErr = eErr;
    vecs.push_back(t);
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one beat at the falling edge and sample just after the next rising edge.
  task automatic applyStimulus(input logic v, input logic ch, input logic go,
                               input logic fin, input logic [15:0] data, input logic clr);
    @(negedge clock);
    in_valid  = v;
    in_ch     = ch;
    in_go     = go;
    in_finish = fin;
    in_data   = data;
    err_clr   = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic eValid, input logic eCh,
                             input logic [15:0] eMin, input logic [15:0] eMax,
                             input logic [15:0] eRange, input logic [7:0] eCnt,
                             input logic [1:0] eErr);
    compare({tag, " out_valid"}, 32'(out_valid), 32'(eValid));
    compare({tag, " error"}, 32'(error), 32'(eErr));
    if (eValid) begin
      compare({tag, " out_ch"}, 32'(out_ch), 32'(eCh));
      compare({tag, " out_min"}, 32'(out_min), 32'(eMin));
      compare({tag, " out_max"}, 32'(out_max), 32'(eMax));
      compare({tag, " out_range"}, 32'(out_range), 32'(eRange));
      compare({tag, " out_count"}, 32'(out_count), 32'(eCnt));
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    clock     = 1'b0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_ch     = 1'b0;
    in_go     = 1'b0;
    in_finish = 1'b0;
    in_data   = 16'h0;
    err_clr   = 1'b0;

    //      v  ch go fin data     clr  eV eCh eMin     eMax     eRange   eCnt eErr
    addVec(1, 0, 1, 0, 16'd5,   0,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 0, 0, 0, 16'd9,   0,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 0, 0, 0, 16'd3,   0,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 0, 0, 1, 16'd7,   0,   1, 0, 16'd3,   16'd9,   16'd6,   8'd4, 2'b00);
    addVec(1, 1, 1, 1, 16'd42,  0,   1, 1, 16'd42,  16'd42,  16'd0,   8'd1, 2'b00);
    addVec(0, 0, 0, 0, 16'd0,   0,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 0, 1, 0, 16'd100, 0,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 1, 1, 0, 16'd10,  0,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 0, 0, 0, 16'd200, 0,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 1, 0, 0, 16'd50,  0,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 0, 0, 1, 16'd150, 0,   1, 0, 16'd100, 16'd200, 16'd100, 8'd3, 2'b00);
    addVec(1, 1, 0, 1, 16'd20,  0,   1, 1, 16'd10,  16'd50,  16'd40,  8'd3, 2'b00);
    addVec(0, 1, 1, 1, 16'd77,  0,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 1, 0, 1, 16'd0,   0,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b10);
    addVec(1, 0, 1, 0, 16'd1,   0,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b10);
    addVec(1, 0, 1, 0, 16'd8,   0,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b11);
    addVec(1, 0, 0, 1, 16'd4,   0,   1, 0, 16'd4,   16'd8,   16'd4,   8'd2, 2'b11);
    addVec(0, 0, 0, 0, 16'd0,   1,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 0, 0, 0, 16'd5,   0,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b01);
    addVec(0, 0, 0, 0, 16'd0,   1,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 0, 0, 0, 16'd5,   1,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b01);
    addVec(0, 0, 0, 0, 16'd0,   1,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 1, 1, 0, 16'd30,  0,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 1, 1, 1, 16'd12,  0,   1, 1, 16'd12,  16'd12,  16'd0,   8'd1, 2'b10);
    addVec(0, 0, 0, 0, 16'd0,   1,   0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 0, 1, 0, 16'hFFFE, 0,  0, 0, 16'd0,   16'd0,   16'd0,   8'd0, 2'b00);
    addVec(1, 0, 0, 1, 16'h0003, 0,  1, 0, SGN_MIN, SGN_MAX, SGN_RANGE, 8'd2, 2'b00);

    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset", 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 8'd0, 2'b00);
    compare("reset out_min", 32'(out_min), 32'd0);
    compare("reset out_count", 32'(out_count), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].v, vecs[k].ch, vecs[k].go, vecs[k].fin, vecs[k].data, vecs[k].clr);
      checkOutput($sformatf("vec%0d", k), vecs[k].eValid, vecs[k].eCh, vecs[k].eMin,
                  vecs[k].eMax, vecs[k].eRange, vecs[k].eCnt, vecs[k].eErr);
    end

    // Result fields hold after the pulse drops.
    applyStimulus(0, 0, 0, 0, 16'd0, 0);
    applyStimulus(0, 0, 0, 0, 16'd0, 0);
    compare("hold out_valid", 32'(out_valid), 32'd0);
    compare("hold out_min", 32'(out_min), 32'(SGN_MIN));
    compare("hold out_max", 32'(out_max), 32'(SGN_MAX));
    compare("hold out_range", 32'(out_range), 32'(SGN_RANGE));
    compare("hold out_count", 32'(out_count), 32'd2);

    // Count saturation: go + 300 samples + finish.
    applyStimulus(1, 0, 1, 0, 16'd500, 0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 0, 0, 0, 16'(500 + (i % 50)), 0);
    end
    compare("sat no early result", 32'(out_valid), 32'd0);
    applyStimulus(1, 0, 0, 1, 16'd520, 0);
    checkOutput("sat", 1'b1, 1'b0, 16'd500, 16'd549, 16'd49, 8'd255, 2'b00);

    // Reset in the middle of a measurement, then a stray finish.
    applyStimulus(1, 1, 1, 0, 16'd7, 0);
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    in_go    = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("midreset", 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 8'd0, 2'b00);
    compare("midreset out_min", 32'(out_min), 32'd0);
    compare("midreset out_max", 32'(out_max), 32'd0);
    compare("midreset out_count", 32'(out_count), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1, 1, 0, 1, 16'd9, 0);
    checkOutput("postreset finish", 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 8'd0, 2'b10);
    compare("postreset out_max", 32'(out_max), 32'd0);
    compare("postreset out_range", 32'(out_range), 32'd0);
    compare("postreset out_count", 32'(out_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/range_tracker.md
Name: range_tracker

Overview:
Multi-channel successor to the single-stream range finder. Tracks min, max, range (max-min) and sample count independently for NCH channels that share one tagged input beat stream. Each finished measurement emits a one-cycle result pulse. Sits between the chip pin mux and the output register bank.

Parameters:
WIDTH, 16, data sample width in bits
NCH, 2, number of independent channels (>=1)
CNT_W, 8, sample-count width; count saturates

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
in_valid  input  1  beat present this cycle
in_ch  input  max(1,$clog2(NCH))  channel tag of beat
in_go  input  1  beat opens a measurement
in_finish  input  1  beat closes a measurement
in_data  input  WIDTH  sample carried by beat
err_clr  input  1  clears all sticky error bits
out_valid  output  1  one-cycle result pulse
out_ch  output  max(1,$clog2(NCH))  channel of result
out_min  output  WIDTH  minimum sample
out_max  output  WIDTH  maximum sample
out_range  output  WIDTH  out_max - out_min, unsigned
out_count  output  CNT_W  samples in measurement, saturating
error  output  NCH  sticky per-channel protocol error

Behaviour:
- Reset: synchronous, active-low. At a clock edge with reset==0: all channels IDLE; per-channel min/max/count = 0; all outputs = 0; error = 0. Takes priority over every other input.
- Per-channel FSM states: IDLE, RUN. Only the channel addressed by in_ch reacts to a beat; beats with in_valid=0 are ignored. in_ch >= NCH: beat dropped, no error.
- Beat kinds (channel C = in_ch):
  - go=1, finish=0, C IDLE: C -> RUN; min = max = in_data; count = 1.
  - go=1, finish=0, C RUN: error[C] set; C restarts as above. Old data is discarded; no result.
  - go=0, finish=0, C RUN: update min/max; count += 1, saturating at 2^CNT_W-1.
  - go=0, finish=0, C IDLE: error[C] set; beat ignored.
  - go=0, finish=1, C RUN: sample included, then result issued; C -> IDLE.
  - go=0, finish=1, C IDLE: error[C] set; no result.
  - go=1, finish=1, C IDLE: single-sample measurement; result min = max = in_data, range 0, count 1; C stays IDLE.
  - go=1, finish=1, C RUN: error[C] set; old data discarded; single-sample result issued; C -> IDLE.
- Result timing: registered. out_valid is high exactly 1 cycle after the closing beat and carries out_ch = C. out_min, out_max, out_range and out_count hold their values until the next result.
- Results can issue on back-to-back cycles from different channels.
- Comparison is unsigned by default; see Optional Feature. out_range = out_max - out_min modulo 2^WIDTH, which is always exact.
- Error bits are sticky. err_clr clears all bits. If err_clr and a new error occur in the same cycle, the new error wins (bit ends set).
- No backpressure; the block is always ready.

Optional Feature:
Macro RANGE_TRACKER_SIGNED_EN.
- Defined: min/max compares treat samples as two's complement; out_range is max-min as unsigned WIDTH bits.
- Undefined: unsigned compares.

Decomposition:
- Package range_tracker_pkg: state enum (IDLE, RUN), beat-kind enum (BEAT_GO, BEAT_SAMPLE, BEAT_FINISH, BEAT_SINGLE), and a result struct typedef {min, max, count}.
- Sub-module range_channel: one channel's FSM, min/max/count registers and error bit. Instantiated NCH times via generate.
- Top level: beat decode, channel select, output register.

Test Plan:
- ch0 beats: go 5; 9; 3; finish 7 -> next cycle out_valid=1, ch 0, min 3, max 9, range 6, count 4.
- ch1 go+finish, data 42 -> out_valid, min = max = 42, range 0, count 1; ch1 stays IDLE; error = 0.
- Interleaved: ch0 go 100, ch1 go 10, ch0 200, ch1 50, ch0 finish 150, ch1 finish 20 -> ch0 result (range 100, count 3) then ch1 result (min 10, max 50, range 40, count 3) on consecutive cycles.
- Errors:
  - finish on IDLE ch1 -> error=2'b10, no out_valid.
  - go, go on ch0 (data 1 then 8), finish 4 -> error[0] set; result min 4, max 8, count 2.
  - err_clr -> error=0.
- Saturation, CNT_W=8: go + 300 samples + finish -> out_count 255. Reset low mid-RUN, then finish -> error set, no result, outputs 0.
- Data 0xFFFE then finish 0x0003 -> with macro: min 0xFFFE, max 0x0003, range 5; without macro: min 0x0003, max 0xFFFE, range 0xFFFB.
